// File: rtl/prog_loader_if.sv
// Byte-stream valid/ready channel into the boot loader.
interface prog_loader_if #(
  parameter int unsigned DataWidth = 8
) ();
  logic                 valid;
  logic                 ready;
  logic                 last;
  logic [DataWidth-1:0] data;

  modport master (
    output valid,
    output data,
    output last,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  last,
    output ready
  );
endinterface

// File: rtl/prog_loader.sv
// Boot-time program loader: streams bytes into program memory and holds the core until done.
// Define PROG_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the program.
module prog_loader #(
  parameter int unsigned DataWidth = 8,
  parameter int unsigned AddrWidth = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  prog_loader_if.slave         in_if,
  output logic                 mem_wr_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [DataWidth-1:0] mem_data_o,
  output logic                 cpu_hold_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [AddrWidth:0]   count_o
);

  localparam int unsigned CntWidth = AddrWidth + 1;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
`ifdef PROG_LOADER_CHECKSUM_EN
    StCheck,
`endif
    StRun,
    StErr
  } state_e;

  state_e                 state_q, state_d;
  logic [AddrWidth-1:0]   ptr_q, ptr_d;
  logic [CntWidth-1:0]    count_q, count_d;
  logic                   mem_wr_q, mem_wr_d;
  logic [AddrWidth-1:0]   mem_addr_q, mem_addr_d;
  logic [DataWidth-1:0]   mem_data_q, mem_data_d;
  logic                   accept;
  logic                   load_end;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [DataWidth-1:0]   csum_q, csum_d;
`endif

  // Ready depends on state only so the upstream source never sees a combinational loop.
  always_comb begin
    in_if.ready = 1'b0;
    unique case (state_q)
      StLoad:  in_if.ready = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
      StCheck: in_if.ready = 1'b1;
`endif
      default: in_if.ready = 1'b0;
    endcase
  end

  assign accept   = in_if.valid & in_if.ready;
  assign load_end = in_if.last | (&ptr_q);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    count_d    = count_q;
    mem_wr_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    if (start_i) begin
      // Restart wins over any byte accepted in the same cycle; that byte is dropped.
      state_d = StLoad;
      ptr_d   = '0;
      count_d = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_d  = '0;
`endif
    end else begin
      case (state_q)
        StLoad: begin
          if (accept) begin
            mem_wr_d   = 1'b1;
            mem_addr_d = ptr_q;
            mem_data_d = in_if.data;
            count_d    = count_q + CntWidth'(1);
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_d     = csum_q ^ in_if.data;
`endif
            if (load_end) begin
`ifdef PROG_LOADER_CHECKSUM_EN
              state_d = StCheck;
`else
              state_d = StRun;
`endif
            end else begin
              ptr_d = ptr_q + AddrWidth'(1);
            end
          end
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        StCheck: begin
          if (accept) begin
            state_d = (in_if.data == csum_q) ? StRun : StErr;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      count_q    <= '0;
      mem_wr_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      count_q    <= count_d;
      mem_wr_q   <= mem_wr_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign mem_wr_o   = mem_wr_q;
  assign mem_addr_o = mem_addr_q;
  assign mem_data_o = mem_data_q;
  assign count_o    = count_q;
  assign cpu_hold_o = (state_q != StRun);
  assign done_o     = (state_q == StRun);
`ifdef PROG_LOADER_CHECKSUM_EN
  assign busy_o     = (state_q == StLoad) | (state_q == StCheck);
  assign err_o      = (state_q == StErr);
`else
  assign busy_o     = (state_q == StLoad);
  assign err_o      = 1'b0;
`endif

endmodule
